// File: rtl/error_metric_accum_if.sv
// Product-pair stream into the error-metric accumulator: valid/ready handshake
// plus the approximate and exact 8x8 products for the same operand pair.
interface error_metric_accum_if;
    // A pair transfers on a rising clk edge where in_valid and in_ready are both 1;
    // the source holds y_approx/y_exact stable while in_valid is high, and in_ready
    // never depends on in_valid.
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_approx;
    logic [15:0] y_exact;

    modport master (
        output in_valid,
        output y_approx,
        output y_exact,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  y_approx,
        input  y_exact,
        output in_ready
    );
endinterface

// File: rtl/error_metric_accum.sv
// Two-stage accumulator of |y_approx - y_exact| over N_SAMPLES pairs (sum, max, count).
// Define ERR_MAX_TRACK_EN to build the max_ed tracker; otherwise max_ed is tied to 0.
module error_metric_accum #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    error_metric_accum_if.slave  in_if,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [15:0]          max_ed,
    output logic [15:0]          err_cnt,
    output logic                 sum_ovf,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  RUN    = 2'd1;
    localparam logic [1:0]  DONE   = 2'd2;
    localparam logic [15:0] N_LAST = 16'(N_SAMPLES);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [15:0]  cnt;
    logic         launch;
    logic         accept;
    logic [15:0]  ed_comb;
    logic         s1_valid;
    logic [15:0]  s1_ed;
    logic [SUM_W:0] sum_wide;

    // start is only honoured outside RUN; it both clears the results and enters RUN.
    assign launch          = start && (state != RUN);
    assign in_if.in_ready  = (state == RUN) && (cnt < N_LAST);
    assign accept          = in_if.in_valid && in_if.in_ready;
    assign done            = (state == DONE);
    assign state_dbg       = state;

    always_comb begin
        ed_comb = 16'd0;
        if (in_if.y_approx >= in_if.y_exact)
            ed_comb = in_if.y_approx - in_if.y_exact;
        else
            ed_comb = in_if.y_exact - in_if.y_approx;
    end

    // cnt hits N_LAST the cycle after the last accept, while that sample sits in
    // stage 1; leaving RUN on that edge lines up with its stage-2 update.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (cnt == N_LAST) state_nxt = DONE;
            DONE:    if (launch) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            s1_valid <= 1'b0;
            s1_ed    <= 16'd0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            if (launch)
                cnt <= 16'd0;
            else if (accept)
                cnt <= cnt + 16'd1;
            if (accept)
                s1_ed <= ed_comb;
        end
    end

    // One spare bit catches the carry out; once saturated the sum stays at all-ones.
    assign sum_wide = {1'b0, sum_ed} + {{(SUM_W - 15){1'b0}}, s1_ed};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_ed  <= '0;
            sum_ovf <= 1'b0;
            err_cnt <= 16'd0;
        end else if (launch) begin
            sum_ed  <= '0;
            sum_ovf <= 1'b0;
            err_cnt <= 16'd0;
        end else if (s1_valid) begin
            if (sum_wide[SUM_W]) begin
                sum_ed  <= '1;
                sum_ovf <= 1'b1;
            end else begin
                sum_ed  <= sum_wide[SUM_W-1:0];
            end
            if (s1_ed != 16'd0)
                err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef ERR_MAX_TRACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            max_ed <= 16'd0;
        else if (launch)
            max_ed <= 16'd0;
        else if (s1_valid && (s1_ed > max_ed))
            max_ed <= s1_ed;
    end
`else
    assign max_ed = 16'd0;
`endif

endmodule

// File: tb/tb_error_metric_accum.sv
// Randomized bench for error_metric_accum: two instances (N=4/SUM_W=32 and
// N=6/SUM_W=16) checked against a plain-arithmetic reference of the run results.
module tb_error_metric_accum;

    localparam int N_A = 4;
    localparam int N_B = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    error_metric_accum_if ifa ();
    error_metric_accum_if ifb ();

    logic        sel = 1'b0;
    logic        v = 1'b0;
    logic        st = 1'b0;
    logic [15:0] ya = 16'd0;
    logic [15:0] ye = 16'd0;

    logic        start_a, start_b;
    logic [31:0] sum_a;
    logic [15:0] sum_b;
    logic [15:0] max_a, max_b, err_a, err_b;
    logic        ovf_a, ovf_b, done_a, done_b;
    logic [1:0]  state_a, state_b;

    assign ifa.in_valid = v && (sel == 1'b0);
    assign ifb.in_valid = v && (sel == 1'b1);
    assign ifa.y_approx = ya;
    assign ifa.y_exact  = ye;
    assign ifb.y_approx = ya;
    assign ifb.y_exact  = ye;
    assign start_a      = st && (sel == 1'b0);
    assign start_b      = st && (sel == 1'b1);

    error_metric_accum #(.N_SAMPLES(N_A), .SUM_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_if(ifa),
        .sum_ed(sum_a), .max_ed(max_a), .err_cnt(err_a),
        .sum_ovf(ovf_a), .done(done_a), .state_dbg(state_a)
    );

    error_metric_accum #(.N_SAMPLES(N_B), .SUM_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_if(ifb),
        .sum_ed(sum_b), .max_ed(max_b), .err_cnt(err_b),
        .sum_ovf(ovf_b), .done(done_b), .state_dbg(state_b)
    );

    // view of whichever instance is selected
    logic        c_ready, c_ovf, c_done;
    logic [47:0] c_sum;
    logic [15:0] c_max, c_err;
    logic [1:0]  c_state;
    assign c_ready = sel ? ifb.in_ready : ifa.in_ready;
    assign c_sum   = sel ? 48'(sum_b) : 48'(sum_a);
    assign c_max   = sel ? max_b : max_a;
    assign c_err   = sel ? err_b : err_a;
    assign c_ovf   = sel ? ovf_b : ovf_a;
    assign c_done  = sel ? done_b : done_a;
    assign c_state = sel ? state_b : state_a;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] q_ap[$];
    logic [15:0] q_ex[$];
    logic [47:0] exp_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_sum"}, c_sum, 0);
        check({pfx, "_max"}, c_max, 0);
        check({pfx, "_err"}, c_err, 0);
        check({pfx, "_ovf"}, c_ovf, 0);
        check({pfx, "_done"}, c_done, 0);
    endtask

    // ---------------- drivers ----------------
    task automatic push_pair(input int a, input int e);
        q_ap.push_back(16'(a));
        q_ex.push_back(16'(e));
    endtask

    task automatic fill_random(input int n, input int mode);
        int a, e;
        q_ap.delete();
        q_ex.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                a = $urandom_range(65535, 0);
                e = $urandom_range(65535, 0);
            end else begin
                a = $urandom_range(3000, 0);
                e = $urandom_range(3000, 0);
            end
            if ($urandom_range(3, 0) == 0) e = a;
            push_pair(a, e);
        end
    endtask

    // Starts a run on the selected instance, feeds q_ap/q_ex, checks the result.
    task automatic run_pairs(input int gap_min, input int gap_max, input bit mid_start);
        longint raw, sat, mx, ec, ed;
        int gap, budget;
        sat = sel ? 64'd65535 : 64'd4294967295;
        raw = 0; mx = 0; ec = 0;
        exp_q.delete();
        foreach (q_ap[i]) begin
            ed = longint'(q_ap[i]) - longint'(q_ex[i]);
            if (ed < 0) ed = -ed;
            raw += ed;
            if (ed > mx) mx = ed;
            if (ed != 0) ec++;
            exp_q.push_back(48'((raw > sat) ? sat : raw));
        end
`ifndef ERR_MAX_TRACK_EN
        mx = 0;
`endif

        @(negedge clk); v = 1'b0; st = 1'b1;
        @(negedge clk); st = 1'b0;
        check_cleared("start");
        check("start_ready", c_ready, 1);

        for (int i = 0; i < q_ap.size(); i++) begin
            gap = $urandom_range(gap_max, gap_min);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                v = 1'b0; st = 1'b0;
                ya = 16'($urandom); ye = 16'($urandom);
                if (g >= 1 && g == gap - 1 && i > 0)
                    check("stall_sum", c_sum, longint'(exp_q[i-1]));
            end
            @(negedge clk);
            v = 1'b1; st = mid_start && (i == 1);
            ya = q_ap[i]; ye = q_ex[i];
            budget = 0;
            while (!c_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("in_ready_run", c_ready, 1);
            @(posedge clk);
        end

        @(negedge clk); v = 1'b0; st = 1'b0;
        check("tail_ready", c_ready, 0);
        check("tail_done", c_done, 0);
        @(negedge clk);
        check("final_done", c_done, 1);
        check("final_state", c_state, 2);
        check("final_sum", c_sum, longint'(exp_q[exp_q.size()-1]));
        check("final_max", c_max, mx);
        check("final_err", c_err, ec);
        check("final_ovf", c_ovf, (raw > sat) ? 1 : 0);

        // pairs offered in DONE must not be taken
        v = 1'b1; ya = 16'd0; ye = 16'd60000;
        repeat (3) @(negedge clk);
        check("hold_sum", c_sum, longint'(exp_q[exp_q.size()-1]));
        check("hold_err", c_err, ec);
        check("hold_ready", c_ready, 0);
        v = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check_cleared("reset");
            check("reset_ready", c_ready, 0);
            check("reset_state", c_state, 0);
        end
        rst_n = 1'b1;

        // IDLE ignores in_valid
        sel = 1'b0;
        v = 1'b1; ya = 16'd7; ye = 16'd9;
        repeat (3) @(negedge clk);
        check("idle_ready", c_ready, 0);
        check("idle_err", c_err, 0);
        v = 1'b0;

        // basic run then the same pairs stalled
        q_ap.delete(); q_ex.delete();
        push_pair(100, 100); push_pair(90, 100); push_pair(300, 256); push_pair(0, 65535);
        run_pairs(0, 0, 1'b0);
        run_pairs(3, 3, 1'b0);
        run_pairs(0, 2, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fill_random(N_A, r % 2);
            run_pairs(0, 3, r[0]);
        end

        // reset one cycle after the 2nd accept
        fill_random(N_A, 0);
        @(negedge clk); st = 1'b1;
        @(negedge clk); st = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v = 1'b1; ya = q_ap[i]; ye = q_ex[i];
            @(posedge clk);
            @(negedge clk);
        end
        v = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        check("midreset_state", c_state, 0);
        check("midreset_ready", c_ready, 0);
        rst_n = 1'b1;
        fill_random(N_A, 1);
        run_pairs(0, 2, 1'b0);

        // 16-bit sum saturation
        sel = 1'b1;
        q_ap.delete(); q_ex.delete();
        push_pair(40000, 0); push_pair(0, 40000);
        push_pair(5, 5); push_pair(1234, 1234); push_pair(0, 0); push_pair(65535, 65535);
        run_pairs(0, 1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            fill_random(N_B, r % 2);
            run_pairs(0, 3, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
